// File: rtl/interfaz_pulsadores_pkg.sv
// Shared constants for the push-button interface: default sizes, debounce
// length for silicon and a short debounce length for simulation.
package interfaz_pulsadores_pkg;

  localparam int N_BTN_DEFAULT    = 6;
  localparam int DB_COUNT_DEFAULT = 500000;  // 10 ms at 50 MHz
  localparam int CW_DEFAULT       = 20;      // 2**CW must exceed DB_COUNT
  localparam int DB_COUNT_SIM     = 4;

endpackage : interfaz_pulsadores_pkg

// File: rtl/interfaz_pulsadores_antirrebote_canal.sv
// One button channel: two-flop synchroniser, stable-time debouncer holding
// the accepted level, and a registered one-cycle pulse on each debounced rise.
module antirrebote_canal
  import interfaz_pulsadores_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic press
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          level_q,    level_d;
  logic          level_dly_q;
  logic          press_q,    press_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= din;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
    end
  end

  // Any cycle where the synchronised pin agrees with the accepted level
  // restarts the stability count; the count never exceeds CNT_LAST.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pulse lands the cycle after the accepted level rises; releases are silent.
  always_comb begin
    press_d = level_q & ~level_dly_q;
  end

  assign level = level_q;
  assign press = press_q;

  cnt_bounded_a: assert property (@(posedge clk) disable iff (!reset)
    cnt_q <= CNT_LAST);

  press_single_a: assert property (@(posedge clk) disable iff (!reset)
    press_q |=> !press_q);

endmodule : antirrebote_canal

// File: rtl/interfaz_pulsadores.sv
// Push-button front end: one debounce channel per button plus a pending-event
// bitmap collected by the control FSM, with a sticky overrun flag.
module interfaz_pulsadores
  import interfaz_pulsadores_pkg::*;
#(
  parameter int N_BTN    = N_BTN_DEFAULT,
  parameter int DB_COUNT = DB_COUNT_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             ev_valid,
  output logic [N_BTN-1:0] ev_mask,
  output logic             ev_overrun,
  input  logic             ev_ack
);

  logic [N_BTN-1:0] ev_mask_q, ev_mask_d;
  logic             ev_overrun_q, ev_overrun_d;
  logic             ev_accept;
  logic [N_BTN-1:0] ev_set;
  logic [N_BTN-1:0] ev_clr;
  logic             ovr_hit;

  for (genvar i = 0; i < N_BTN; i++) begin : g_canal
    antirrebote_canal #(
      .DB_COUNT(DB_COUNT),
      .CW      (CW)
    ) u_canal (
      .clk  (clk),
      .reset(reset),
      .din  (btn_in[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_mask_q    <= '0;
      ev_overrun_q <= 1'b0;
    end else begin
      ev_mask_q    <= ev_mask_d;
      ev_overrun_q <= ev_overrun_d;
    end
  end

  // Handshake: ev_valid/ev_mask describe the pending presses; an ev_ack seen
  // while ev_valid=1 consumes every bit shown in that cycle, and an ev_ack
  // while ev_valid=0 is ignored. A press arriving with the ack survives it.
  always_comb begin
    ev_accept    = ev_ack & ev_valid;
    ev_set       = btn_press;
    ev_clr       = ev_accept ? ev_mask_q : '0;
    ev_mask_d    = ev_set | (ev_mask_q & ~ev_clr);
    ovr_hit      = |(ev_set & ev_mask_q & ~ev_clr);
    ev_overrun_d = ev_overrun_q;
    if (ovr_hit) begin
      ev_overrun_d = 1'b1;
    end else if (ev_accept) begin
      ev_overrun_d = 1'b0;
    end
  end

  assign ev_valid   = |ev_mask_q;
  assign ev_mask    = ev_mask_q;
  assign ev_overrun = ev_overrun_q;

endmodule : interfaz_pulsadores

// File: tb/tb_interfaz_pulsadores.sv
// Bench for interfaz_pulsadores: directed scenarios then random button/ack
// traffic, checked against a window-based reference model and a press queue.
module tb_interfaz_pulsadores;
  import interfaz_pulsadores_pkg::*;

  localparam int N  = 6;
  localparam int DB = DB_COUNT_SIM;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic         ev_ack = 1'b0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic         ev_valid;
  logic [N-1:0] ev_mask;
  logic         ev_overrun;

  int checks   = 0;
  int failures = 0;

  interfaz_pulsadores #(
    .N_BTN   (N),
    .DB_COUNT(DB),
    .CW      (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .ev_valid  (ev_valid),
    .ev_mask   (ev_mask),
    .ev_overrun(ev_overrun),
    .ev_ack    (ev_ack)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Level flips once the synchronised pin (pin delayed two samples) has
  // disagreed with it for the last DB samples in a row.
  logic [N-1:0] raw_h[$];
  logic [N-1:0] level_m = '0;
  logic [N-1:0] rose_m  = '0;
  logic [N-1:0] press_m = '0;
  logic [N-1:0] mask_m  = '0;
  logic         ovr_m   = 1'b0;
  logic [N-1:0] exp_q[$];

  always @(posedge clk or negedge reset) begin : model
    logic         acc;
    logic [N-1:0] clr;
    logic         all_diff;
    if (!reset) begin
      raw_h.delete();
      for (int k = 0; k <= DB; k++) raw_h.push_back('0);
      level_m = '0;
      rose_m  = '0;
      press_m = '0;
      mask_m  = '0;
      ovr_m   = 1'b0;
      exp_q.delete();
    end else begin
      acc = ev_ack && (mask_m != '0);
      clr = acc ? mask_m : '0;
      if ((press_m & mask_m & ~clr) != '0) ovr_m = 1'b1;
      else if (acc)                        ovr_m = 1'b0;
      mask_m  = press_m | (mask_m & ~clr);
      press_m = rose_m;
      rose_m  = '0;
      for (int i = 0; i < N; i++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DB; k++)
          if (raw_h[k][i] == level_m[i]) all_diff = 1'b0;
        if (all_diff) begin
          level_m[i] = ~level_m[i];
          if (level_m[i]) rose_m[i] = 1'b1;
        end
      end
      if (press_m != '0) exp_q.push_back(press_m);
      raw_h.push_front(btn_in);
      void'(raw_h.pop_back());
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always begin : monitor
    logic [N-1:0] e;
    @(negedge clk);
    #1;
    chk("level", btn_level, level_m);
    chk("mask", ev_mask, mask_m);
    chk("valid", ev_valid, (mask_m != '0));
    chk("overrun", ev_overrun, ovr_m);
    chk("press_timing", (btn_press != '0), (press_m != '0));
    if (btn_press != '0) begin
      if (exp_q.size() == 0) begin
        chk("press_unexpected", btn_press, '0);
      end else begin
        e = exp_q.pop_front();
        chk("press_val", btn_press, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_press(input int b);
    logic found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (btn_press[b]) begin
        found = 1'b1;
        break;
      end
    end
    chk("press_seen", found, 1'b1);
  endtask

  task automatic ack_once();
    ev_ack = 1'b1;
    cycles(1);
    ev_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int hold [N];
    // 1. reset held with all buttons pressed
    reset  = 1'b0;
    btn_in = 6'h3F;
    cycles(3);
    #1;
    chk("rst_level", btn_level, 6'h00);
    chk("rst_valid", ev_valid, 1'b0);
    chk("rst_press", btn_press, 6'h00);
    @(negedge clk);
    reset = 1'b1;
    cycles(5);
    chk("lat_level_early", btn_level, 6'h00);
    cycles(1);
    chk("lat_level", btn_level, 6'h3F);
    cycles(1);
    chk("lat_press", btn_press, 6'h3F);
    cycles(1);
    chk("lat_mask", ev_mask, 6'h3F);
    ack_once();
    chk("ack_all", ev_mask, 6'h00);
    btn_in = 6'h00;
    cycles(10);

    // 2. glitch shorter than the debounce window
    btn_in[0] = 1'b1;
    cycles(3);
    btn_in[0] = 1'b0;
    cycles(10);
    chk("glitch_level", btn_level, 6'h00);
    chk("glitch_valid", ev_valid, 1'b0);

    // 3. single press and acknowledge
    btn_in[2] = 1'b1;
    wait_press(2);
    cycles(1);
    chk("p3_mask", ev_mask, 6'h04);
    chk("p3_valid", ev_valid, 1'b1);
    ack_once();
    chk("p3_mask_clr", ev_mask, 6'h00);
    chk("p3_valid_clr", ev_valid, 1'b0);

    // 4. new press coincides with ack of the same bit
    btn_in[2] = 1'b0;
    cycles(10);
    btn_in[2] = 1'b1;
    wait_press(2);
    cycles(1);
    btn_in[2] = 1'b0;
    cycles(10);
    btn_in[2] = 1'b1;
    wait_press(2);
    ack_once();
    chk("p4_mask", ev_mask, 6'h04);
    chk("p4_overrun", ev_overrun, 1'b0);

    // 5. second press while the first is still pending
    ack_once();
    btn_in[2] = 1'b0;
    btn_in[1] = 1'b1;
    wait_press(1);
    btn_in[1] = 1'b0;
    cycles(10);
    btn_in[1] = 1'b1;
    wait_press(1);
    cycles(1);
    chk("p5_overrun", ev_overrun, 1'b1);
    chk("p5_mask", ev_mask, 6'h02);
    ack_once();
    chk("p5_mask_clr", ev_mask, 6'h00);
    chk("p5_overrun_clr", ev_overrun, 1'b0);

    // 6. reset mid-count with an event pending
    btn_in = 6'h08;
    wait_press(3);
    cycles(1);
    chk("p6_mask", ev_mask, 6'h08);
    btn_in[4] = 1'b1;
    cycles(4);
    reset = 1'b0;
    #1;
    chk("p6_rst_mask", ev_mask, 6'h00);
    chk("p6_rst_valid", ev_valid, 1'b0);
    chk("p6_rst_level", btn_level, 6'h00);
    cycles(2);
    reset = 1'b1;
    cycles(5);
    chk("p6_restart_early", btn_level, 6'h00);
    cycles(1);
    chk("p6_restart", btn_level, 6'h18);
    cycles(4);

    // 7. random button traffic with random acks and one reset pulse
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          btn_in[i] = 1'($urandom_range(0, 1));
          hold[i]   = $urandom_range(1, 9);
        end else begin
          hold[i]--;
        end
      end
      ev_ack = ($urandom_range(0, 3) == 0);
      reset  = !(c >= 700 && c < 702);
      cycles(1);
    end
    ev_ack = 1'b0;
    reset  = 1'b1;
    btn_in = '0;
    cycles(20);
    chk("drain_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_interfaz_pulsadores
